rr_timeout_arbiter: RTL and testbench

Parametrised N-port round-robin output arbiter for the NoC router, successor to the fixed 5-port L/N/E/W/S arbiter. It grants one input port at a time, holds that grant while the port keeps requesting, and forcibly releases it once a per-port timeout, loaded from the packet header's length field, expires. Unlike the 5-port block it rotates priority fairly across all ports and never wraps its timeout counter. One instance sits on each router output port, with its grant vector driving the crossbar select.

---
 rtl/noc_arb_pkg.sv | 14 +
 rtl/rr_timeout_arbiter_if.sv | 28 ++
 rtl/rr_timeout_arbiter_port_timer.sv | 33 +++
 rtl/rr_timeout_arbiter.sv | 133 +++++++++++++
 tb/tb_rr_timeout_arbiter.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// Shared NoC arbiter defaults: port count, field widths, header flit id and arbiter state encoding.
package noc_arb_pkg;

  localparam int unsigned DEF_NPORTS = 5;
  localparam int unsigned DEF_LEN_W  = 12;
  localparam int unsigned DEF_FID_W  = 3;
  localparam int unsigned HEADER_ID  = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_timeout_arbiter_if.sv
// Request/grant bundle between router input ports and one output arbiter.
// ARB_STALL_CNT_EN adds the stall_clr / stall_max pair.
interface rr_timeout_arbiter_if #(
  parameter int unsigned NPORTS = noc_arb_pkg::DEF_NPORTS,
  parameter int unsigned LEN_W  = noc_arb_pkg::DEF_LEN_W,
  parameter int unsigned FID_W  = noc_arb_pkg::DEF_FID_W
);
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0]       req;
  logic [NPORTS-1:0]       grant;
  logic                    idle;
  logic [NPORTS-1:0]       timeout;
`ifdef ARB_STALL_CNT_EN
  logic                    stall_clr;
  logic [LEN_W-1:0]        stall_max;

  modport master (output flit_id, length, req, stall_clr,
                  input  grant, idle, timeout, stall_max);
  modport slave  (input  flit_id, length, req, stall_clr,
                  output grant, idle, timeout, stall_max);
`else
  modport master (output flit_id, length, req,
                  input  grant, idle, timeout);
  modport slave  (input  flit_id, length, req,
                  output grant, idle, timeout);
`endif
endinterface

// File: rtl/rr_timeout_arbiter_port_timer.sv
// Per-port hold timer: limit latched from header flits, saturating hold counter, timesup compare.
module arb_port_timer #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             header,
  input  logic [LEN_W-1:0] length,
  input  logic             hold,
  output logic             timesup
);

  logic [LEN_W-1:0] limit_q;
  logic [LEN_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      if (header)
        limit_q <= length;
      if (hold)
        count_q <= (count_q == '1) ? count_q : count_q + 1'b1;
      else
        count_q <= '0;
    end
  end

  // >= so a limit reloaded below the running count ends the hold at once
  assign timesup = (count_q >= limit_q);

endmodule

// File: rtl/rr_timeout_arbiter.sv
// N-port round-robin output arbiter with per-port hold timeout loaded from header length.
// Optional ARB_STALL_CNT_EN: tracks the longest run of cycles any port waited with req high.
module rr_timeout_arbiter #(
  parameter int unsigned NPORTS    = noc_arb_pkg::DEF_NPORTS,
  parameter int unsigned LEN_W     = noc_arb_pkg::DEF_LEN_W,
  parameter int unsigned FID_W     = noc_arb_pkg::DEF_FID_W,
  parameter int unsigned HEADER_ID = noc_arb_pkg::HEADER_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_timeout_arbiter_if.slave  bus
);
  import noc_arb_pkg::*;

  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan base+1 .. base+NPORTS; excl_base drops the final slot (the base port itself).
  function automatic pick_t rr_pick(input logic [NPORTS-1:0] r,
                                    input logic [IDX_W-1:0]  base,
                                    input logic              excl_base);
    pick_t       res;
    int unsigned p;
    res = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      p = (32'(base) + k) % NPORTS;
      if (!res.valid && r[p] && !(excl_base && k == NPORTS)) begin
        res.valid = 1'b1;
        res.idx   = IDX_W'(p);
      end
    end
    return res;
  endfunction

  arb_state_e        state_q;
  logic [NPORTS-1:0] grant_q;
  logic [NPORTS-1:0] timeout_q;
  logic [IDX_W-1:0]  last_q;
  logic [NPORTS-1:0] timesup;
  logic [NPORTS-1:0] hold_vec;
  logic [NPORTS-1:0] timeout_d;
  logic              owned;
  logic              hold;
  pick_t             pick;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    arb_port_timer #(.LEN_W(LEN_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .header  (bus.flit_id[i*FID_W +: FID_W] == FID_W'(HEADER_ID)),
      .length  (bus.length[i*LEN_W +: LEN_W]),
      .hold    (hold_vec[i]),
      .timesup (timesup[i])
    );
  end

  // While busy, last_q is the current owner, so it doubles as the owner index.
  always_comb begin
    owned     = (state_q == ARB_BUSY);
    hold      = owned && bus.req[last_q] && !timesup[last_q];
    pick      = rr_pick(bus.req, last_q, owned);
    hold_vec  = '0;
    timeout_d = '0;
    if (hold)
      hold_vec[last_q] = 1'b1;
    if (owned && !hold && bus.req[last_q])
      timeout_d[last_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      timeout_q <= '0;
      last_q    <= IDX_W'(NPORTS - 1);
    end else begin
      timeout_q <= timeout_d;
      if (!hold) begin
        if (pick.valid) begin
          state_q <= ARB_BUSY;
          grant_q <= NPORTS'(1) << pick.idx;
          last_q  <= pick.idx;
        end else begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
        end
      end
    end
  end

  assign bus.grant   = grant_q;
  assign bus.idle    = (state_q == ARB_IDLE);
  assign bus.timeout = timeout_q;

`ifdef ARB_STALL_CNT_EN
  logic [LEN_W-1:0] wait_q [NPORTS];
  logic [LEN_W-1:0] wait_d [NPORTS];
  logic [LEN_W-1:0] stall_q;
  logic [LEN_W-1:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      wait_d[i] = '0;
      if (bus.req[i] && !grant_q[i])
        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + 1'b1;
      if (wait_d[i] > stall_d)
        stall_d = wait_d[i];
    end
    if (bus.stall_clr)
      stall_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      for (int unsigned i = 0; i < NPORTS; i++)
        wait_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      for (int unsigned i = 0; i < NPORTS; i++)
        wait_q[i] <= wait_d[i];
    end
  end

  assign bus.stall_max = stall_q;
`endif

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed, table-driven check of rr_timeout_arbiter with the default 5-port configuration.
module tb_rr_timeout_arbiter;

  localparam int unsigned NP = 5;
  localparam int unsigned LW = 12;
  localparam int unsigned FW = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_timeout_arbiter_if #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW)) bus ();

  rr_timeout_arbiter #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW), .HEADER_ID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ARB_STALL_CNT_EN
  initial bus.stall_clr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] hdr;
    logic [LW-1:0] len;
    int unsigned   rep;
    logic [NP-1:0] g;
    logic          idle;
    logic [NP-1:0] to;
  } vec_t;

  vec_t tbl [21];

  task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] h, input logic [LW-1:0] l);
    bus.req = r;
    for (int i = 0; i < int'(NP); i++) begin
      bus.flit_id[i*FW +: FW] = h[i] ? 3'd1 : 3'd0;
      bus.length[i*LW +: LW]  = l;
    end
  endtask

  task automatic check(input string tag, input logic [NP-1:0] eg, input logic ei, input logic [NP-1:0] et);
    checks++;
    if (bus.grant !== eg) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", tag, bus.grant, eg);
    end
    checks++;
    if (bus.idle !== ei) begin
      errors++;
      $display("FAIL %s idle: got %b expected %b", tag, bus.idle, ei);
    end
    checks++;
    if (bus.timeout !== et) begin
      errors++;
      $display("FAIL %s timeout: got %b expected %b", tag, bus.timeout, et);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive('0, '0, '0);

    //        req       hdr       len  rep grant     idle timeout
    tbl[0]  = '{5'b00001, 5'b00001, 12'd3,  1, 5'b00001, 1'b0, 5'b00000};
    tbl[1]  = '{5'b00001, 5'b00000, 12'd0,  3, 5'b00001, 1'b0, 5'b00000};
    tbl[2]  = '{5'b00001, 5'b00000, 12'd0,  1, 5'b00000, 1'b1, 5'b00001};
    tbl[3]  = '{5'b00001, 5'b00000, 12'd0,  1, 5'b00001, 1'b0, 5'b00000};
    tbl[4]  = '{5'b00000, 5'b00000, 12'd0,  1, 5'b00000, 1'b1, 5'b00000};
    tbl[5]  = '{5'b10101, 5'b10101, 12'd1,  1, 5'b00100, 1'b0, 5'b00000};
    tbl[6]  = '{5'b10101, 5'b00000, 12'd0,  1, 5'b00100, 1'b0, 5'b00000};
    tbl[7]  = '{5'b10101, 5'b00000, 12'd0,  1, 5'b10000, 1'b0, 5'b00100};
    tbl[8]  = '{5'b10101, 5'b00000, 12'd0,  1, 5'b10000, 1'b0, 5'b00000};
    tbl[9]  = '{5'b10101, 5'b00000, 12'd0,  1, 5'b00001, 1'b0, 5'b10000};
    tbl[10] = '{5'b10101, 5'b00000, 12'd0,  1, 5'b00001, 1'b0, 5'b00000};
    tbl[11] = '{5'b10101, 5'b00000, 12'd0,  1, 5'b00100, 1'b0, 5'b00001};
    tbl[12] = '{5'b00000, 5'b00000, 12'd0,  1, 5'b00000, 1'b1, 5'b00000};
    tbl[13] = '{5'b01000, 5'b01000, 12'd10, 1, 5'b01000, 1'b0, 5'b00000};
    tbl[14] = '{5'b01000, 5'b00000, 12'd0,  1, 5'b01000, 1'b0, 5'b00000};
    tbl[15] = '{5'b01010, 5'b00000, 12'd0,  1, 5'b01000, 1'b0, 5'b00000};
    tbl[16] = '{5'b00010, 5'b00010, 12'd20, 1, 5'b00010, 1'b0, 5'b00000};
    tbl[17] = '{5'b00010, 5'b00000, 12'd0,  7, 5'b00010, 1'b0, 5'b00000};
    tbl[18] = '{5'b00010, 5'b00010, 12'd2,  1, 5'b00010, 1'b0, 5'b00000};
    tbl[19] = '{5'b00010, 5'b00000, 12'd0,  1, 5'b00000, 1'b1, 5'b00010};
    tbl[20] = '{5'b00000, 5'b00000, 12'd0,  1, 5'b00000, 1'b1, 5'b00000};

    #2;
    check("in_reset", '0, 1'b1, '0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset_idle_%0d", c), '0, 1'b1, '0);
    end

    for (int v = 0; v < 21; v++) begin
      for (int r = 0; r < int'(tbl[v].rep); r++) begin
        @(negedge clk);
        drive(tbl[v].req, tbl[v].hdr, tbl[v].len);
        @(posedge clk); #1;
        check($sformatf("vec%0d_%0d", v, r), tbl[v].g, tbl[v].idle, tbl[v].to);
      end
    end

    // asynchronous reset mid-grant, then fresh arbitration with limit 0 everywhere
    @(negedge clk);
    drive(5'b00100, '0, '0);
    @(posedge clk); #1;
    check("pre_rst_grant", 5'b00100, 1'b0, '0);
    #3 rst = 1'b0;
    #1 check("async_rst", '0, 1'b1, '0);
    @(negedge clk);
    drive(5'b11111, '0, '0);
    @(posedge clk); #1;
    check("rst_held", '0, 1'b1, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_port0", 5'b00001, 1'b0, '0);
    @(posedge clk); #1;
    check("limit0_handoff1", 5'b00010, 1'b0, 5'b00001);
    @(posedge clk); #1;
    check("limit0_handoff2", 5'b00100, 1'b0, 5'b00010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
